edge_rate_meter: RTL and testbench

- Consumes the single-cycle edge pulses produced by the edge-detector stage.
- Measures two things:
  - the number of edges within a fixed gate window of GATE_CYCLES clocks (frequency);
  - the clock-cycle distance between consecutive edges (period).
- Results are registered and announced with one-cycle valid strobes for downstream display or bus logic.

---
 rtl/edge_rate_meter.sv | 141 ++++++++++++++
 tb/tb_edge_rate_meter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_rate_meter.sv
// edge_rate_meter: counts edge pulses over a fixed gate window and measures
// the clock distance between consecutive edges.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for in_enable; edges ignored, counters held
// ST_GATE | counting window open; gate timer runs, period path active
module edge_rate_meter #(
   parameter int GATE_CYCLES = 1000000,
   parameter int CNT_BITS    = 16,
   parameter int PERIOD_BITS = 24
) (
   input  logic                   in_clk,
   input  logic                   in_rst,
   input  logic                   in_enable,
   input  logic                   in_edge,
   output logic [CNT_BITS-1:0]    out_count,
   output logic                   out_overflow,
   output logic                   out_valid,
   output logic [PERIOD_BITS-1:0] out_period,
   output logic                   out_period_valid
);

   localparam int TMR_BITS = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(GATE_CYCLES - 1);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_GATE = 1'b1;

   logic                   state;
   logic [TMR_BITS-1:0]    gate_tmr;
   logic [CNT_BITS-1:0]    edge_cnt;
   logic                   ovf_flag;
   logic [PERIOD_BITS-1:0] per_cnt;
   logic                   first_seen;

   logic                   win_last;
   logic [CNT_BITS-1:0]    cnt_next;
   logic                   ovf_next;
   logic [PERIOD_BITS-1:0] per_inc;
   logic                   per_active;

   // Saturating next-count and window-end decode for the current cycle.
   always_comb begin
      win_last = 1'b0;
      cnt_next = edge_cnt;
      ovf_next = ovf_flag;
      per_inc  = per_cnt;
      if (gate_tmr == TMR_LAST) begin
         win_last = 1'b1;
      end
      if (in_edge) begin
         if (&edge_cnt) begin
            ovf_next = 1'b1;
         end else begin
            cnt_next = edge_cnt + CNT_BITS'(1);
         end
      end
      if (!(&per_cnt)) begin
         per_inc = per_cnt + PERIOD_BITS'(1);
      end
   end

   // An abort cycle (enable dropped before the last gate cycle) is not
   // measured, so the period path only runs while the window is live.
   assign per_active = (state == ST_GATE) && (in_enable || win_last);

   // Gate FSM, window timer, edge counter and frequency result register.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state        <= ST_IDLE;
         gate_tmr     <= '0;
         edge_cnt     <= '0;
         ovf_flag     <= 1'b0;
         out_count    <= '0;
         out_overflow <= 1'b0;
         out_valid    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_enable) begin
                  state    <= ST_GATE;
                  gate_tmr <= '0;
                  edge_cnt <= '0;
                  ovf_flag <= 1'b0;
               end
            end
            ST_GATE: begin
               if (win_last) begin
                  out_count    <= cnt_next;
                  out_overflow <= ovf_next;
                  out_valid    <= 1'b1;
                  gate_tmr     <= '0;
                  edge_cnt     <= '0;
                  ovf_flag     <= 1'b0;
                  state        <= in_enable ? ST_GATE : ST_IDLE;
               end else if (!in_enable) begin
                  state <= ST_IDLE;
               end else begin
                  gate_tmr <= gate_tmr + TMR_BITS'(1);
                  edge_cnt <= cnt_next;
                  ovf_flag <= ovf_next;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Period path: edge-to-edge cycle distance, continuous across windows.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         per_cnt          <= '0;
         first_seen       <= 1'b0;
         out_period       <= '0;
         out_period_valid <= 1'b0;
      end else begin
         out_period_valid <= 1'b0;
         if (state == ST_IDLE) begin
            if (in_enable) begin
               per_cnt    <= '0;
               first_seen <= 1'b0;
            end
         end else if (per_active) begin
            if (in_edge) begin
               per_cnt <= PERIOD_BITS'(1);
               if (first_seen) begin
                  out_period       <= per_cnt;
                  out_period_valid <= 1'b1;
               end else begin
                  first_seen <= 1'b1;
               end
            end else begin
               per_cnt <= per_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_edge_rate_meter.sv
// tb_edge_rate_meter: table-driven sessions plus hand-written corner cases;
// expected window and period results are queued when stimulus is built and
// popped when the corresponding strobe appears.
module tb_edge_rate_meter;

   localparam int GATE = 100;
   localparam int CB   = 4;
   localparam int PB   = 6;

   logic          in_clk = 1'b0;
   logic          in_rst;
   logic          in_enable;
   logic          in_edge;
   logic [CB-1:0] out_count;
   logic          out_overflow;
   logic          out_valid;
   logic [PB-1:0] out_period;
   logic          out_period_valid;

   always #5 in_clk = ~in_clk;

   edge_rate_meter #(
      .GATE_CYCLES (GATE),
      .CNT_BITS    (CB),
      .PERIOD_BITS (PB)
   ) dut (
      .in_clk           (in_clk),
      .in_rst           (in_rst),
      .in_enable        (in_enable),
      .in_edge          (in_edge),
      .out_count        (out_count),
      .out_overflow     (out_overflow),
      .out_valid        (out_valid),
      .out_period       (out_period),
      .out_period_valid (out_period_valid)
   );

   typedef struct {
      int rel;
      int count;
      int ovf;
   } win_exp_t;

   typedef struct {
      int rel;
      int period;
   } per_exp_t;

   typedef struct {
      int n_cycles;
      int spacing;
      int phase;
      int exp_count;
      int exp_ovf;
      int exp_period;
   } vec_t;

   win_exp_t win_q[$];
   per_exp_t per_q[$];
   vec_t     vecs[7];

   int n_vec     = 0;
   int n_miss    = 0;
   int cyc       = 0;
   int gate0_cyc = 0;
   bit edge_map[0:399];

   int last_count  = 0;
   int last_ovf    = 0;
   int last_period = 0;

   always @(posedge in_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: strobed data against the scoreboard, held data against the
   // last expected result.
   initial begin : monitor
      win_exp_t w;
      per_exp_t p;
      forever begin
         @(negedge in_clk);
         if (in_rst) begin
            last_count  = 0;
            last_ovf    = 0;
            last_period = 0;
         end else begin
            if (out_valid) begin
               if (win_q.size() == 0) begin
                  check("unexpected_out_valid", 1, 0);
               end else begin
                  w = win_q.pop_front();
                  check("win_time", cyc - gate0_cyc, w.rel);
                  check("count", int'(out_count), w.count);
                  check("overflow", int'(out_overflow), w.ovf);
                  last_count = w.count;
                  last_ovf   = w.ovf;
               end
            end else begin
               check("count_hold", int'(out_count), last_count);
               check("overflow_hold", int'(out_overflow), last_ovf);
            end
            if (out_period_valid) begin
               if (per_q.size() == 0) begin
                  check("unexpected_period_valid", 1, 0);
               end else begin
                  p = per_q.pop_front();
                  check("period_time", cyc - gate0_cyc, p.rel);
                  check("period", int'(out_period), p.period);
                  last_period = p.period;
               end
            end else begin
               check("period_hold", int'(out_period), last_period);
            end
         end
      end
   end

   // mode 0: full windows, enable dropped on the last gate cycle
   // mode 1: enable dropped at gate cycle n (abort)
   // mode 2: reset pulsed at gate cycle n
   task automatic run_session(input int n, input int mode);
      in_enable = 1'b1;
      in_edge   = 1'b0;
      @(posedge in_clk); #1;
      for (int g = 0; g < n; g++) begin
         in_enable = (mode != 0) || (g != n - 1);
         in_edge   = edge_map[g];
         @(posedge in_clk); #1;
         if (g == 0) gate0_cyc = cyc;
      end
      if (mode == 1) begin
         in_enable = 1'b0;
         in_edge   = 1'b0;
         @(posedge in_clk); #1;
      end else if (mode == 2) begin
         in_edge = 1'b0;
         in_rst  = 1'b1;
         #1;
         check("rst_count", int'(out_count), 0);
         check("rst_overflow", int'(out_overflow), 0);
         check("rst_valid", int'(out_valid), 0);
         check("rst_period", int'(out_period), 0);
         check("rst_period_valid", int'(out_period_valid), 0);
         @(posedge in_clk); #1;
         in_enable = 1'b0;
         in_rst    = 1'b0;
      end
      in_enable = 1'b0;
      in_edge   = 1'b0;
      repeat (3) @(posedge in_clk);
      #1;
      for (int g = 0; g < 400; g++) edge_map[g] = 1'b0;
   endtask

   task automatic push_win(input int rel, input int count, input int ovf);
      win_exp_t w;
      w.rel = rel; w.count = count; w.ovf = ovf;
      win_q.push_back(w);
   endtask

   task automatic push_per(input int rel, input int period);
      per_exp_t p;
      p.rel = rel; p.period = period;
      per_q.push_back(p);
   endtask

   task automatic set_edge(input int g);
      edge_map[g] = 1'b1;
   endtask

   initial begin
      //          n    spc  ph  count ovf period
      vecs[0] = '{300,  10,  3,  10,  0,  10};
      vecs[1] = '{200,  10,  0,  10,  0,  10};
      vecs[2] = '{200,  10,  9,  10,  0,  10};
      vecs[3] = '{100,   1,  0,  15,  1,   1};
      vecs[4] = '{300, 100, 50,   1,  0,  63};
      vecs[5] = '{100,   7,  0,  15,  0,   7};
      vecs[6] = '{100,   6,  0,  15,  1,   6};

      for (int g = 0; g < 400; g++) edge_map[g] = 1'b0;
      in_rst    = 1'b1;
      in_enable = 1'b0;
      in_edge   = 1'b0;
      repeat (3) @(posedge in_clk);
      #1;
      check("reset_count", int'(out_count), 0);
      check("reset_overflow", int'(out_overflow), 0);
      check("reset_valid", int'(out_valid), 0);
      check("reset_period", int'(out_period), 0);
      check("reset_period_valid", int'(out_period_valid), 0);
      in_rst = 1'b0;
      repeat (2) @(posedge in_clk);
      #1;

      for (int v = 0; v < 7; v++) begin
         bit first;
         first = 1'b1;
         for (int w = 0; w < vecs[v].n_cycles / GATE; w++)
            push_win(w * GATE + GATE - 1, vecs[v].exp_count, vecs[v].exp_ovf);
         for (int g = 0; g < vecs[v].n_cycles; g++) begin
            if ((g % vecs[v].spacing) == vecs[v].phase) begin
               set_edge(g);
               if (!first) push_per(g, vecs[v].exp_period);
               first = 1'b0;
            end
         end
         run_session(vecs[v].n_cycles, 0);
      end

      // Saturated window followed by a 3-edge window: overflow must clear.
      for (int g = 0; g < 100; g++) begin
         set_edge(g);
         if (g > 0) push_per(g, 1);
      end
      set_edge(110); push_per(110, 11);
      set_edge(120); push_per(120, 10);
      set_edge(130); push_per(130, 10);
      push_win(99, 15, 1);
      push_win(199, 3, 0);
      run_session(200, 0);

      // Edges on the last cycle of one window and first of the next.
      set_edge(99);
      set_edge(100);
      push_win(99, 1, 0);
      push_win(199, 1, 0);
      push_per(100, 1);
      run_session(200, 0);

      // Abort at gate cycle 50: outputs hold, then a fresh window.
      set_edge(5);
      run_session(50, 1);
      check("abort_count_hold", int'(out_count), 1);
      check("abort_overflow_hold", int'(out_overflow), 0);
      check("abort_period_hold", int'(out_period), 1);
      set_edge(20);
      set_edge(40);
      push_win(99, 2, 0);
      push_per(40, 20);
      run_session(100, 0);

      // Reset at gate cycle 30 after 5 edges, then a window from zero.
      for (int k = 0; k < 5; k++) begin
         set_edge(k * 4);
         if (k > 0) push_per(k * 4, 4);
      end
      run_session(30, 2);
      set_edge(10);
      set_edge(20);
      push_win(99, 2, 0);
      push_per(20, 10);
      run_session(100, 0);

      check("win_queue_drained", win_q.size(), 0);
      check("period_queue_drained", per_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
